// File: rtl/event_byte_serializer_pkg.sv
// Shared types and sizing helpers for the event byte serializer.
// Also imported by the upstream event filter and its benches.
package event_byte_serializer_pkg;

  localparam int COORD_W_DEF = 4;
  localparam int TS_W_DEF    = 6;
  localparam int DEPTH_DEF   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic int evt_w(input int cw, input int tw);
    return 2 * cw + tw + 1;
  endfunction

  function automatic int nbytes(input int ew);
    return (ew + 7) / 8;
  endfunction

endpackage

// File: rtl/event_byte_serializer_fifo.sv
// Registered event FIFO; an entry written this cycle is not
// visible at rdata_o until the next cycle.
module event_byte_serializer_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/event_byte_serializer.sv
// Buffers (x,y,t,p) events and streams them MSB-first as bytes
// over a valid/ready port; counts events dropped on overflow.
module event_byte_serializer
  import event_byte_serializer_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int TS_W    = TS_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [TS_W-1:0]    in_t,
  input  logic               in_p,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  input  logic               clr_drop,
  output logic [7:0]         drop_count,
  output logic [LVL_W-1:0]   fifo_level
);

  localparam int EVT_W = evt_w(COORD_W, TS_W);
  localparam int NB    = nbytes(EVT_W);
  localparam int SR_W  = NB * 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  logic [EVT_W-1:0] evt_in;
  logic [EVT_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [SR_W-1:0]  rd_word;
  logic [SR_W-1:0]  sh_next;

  state_e           state_q, state_d;
  logic [SR_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       od_q, od_d;
  logic             ov_q, ov_d;
  logic             ol_q, ol_d;
  logic [7:0]       drop_q, drop_d;
  logic             load;

  assign evt_in = {in_p, in_x, in_y, in_t};
  assign push   = in_valid && !fifo_full;
  assign drop   = in_valid && fifo_full;

  event_byte_serializer_fifo #(
    .W     (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (evt_in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    rd_word = '0;
    rd_word[EVT_W-1:0] = fifo_rdata;
    sh_next = shreg_q << 8;
  end

  // A load happens from IDLE or straight after the last byte
  // handshake, so consecutive events go out with no bubble.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    od_d    = od_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_SEND: begin
        if (ov_q && out_ready) begin
          if (!ol_q) begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = sh_next;
            od_d    = sh_next[SR_W-1 -: 8];
            ol_d    = (idx_d == LAST_IDX);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            ov_d    = 1'b0;
            ol_d    = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      state_d = ST_SEND;
      shreg_d = rd_word;
      idx_d   = '0;
      ov_d    = 1'b1;
      od_d    = rd_word[SR_W-1 -: 8];
      ol_d    = (NB == 1);
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (clr_drop) begin
      drop_d = {7'd0, drop};
    end else if (drop && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      od_q    <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data   = od_q;
  assign out_valid  = ov_q;
  assign out_last   = ol_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_event_byte_serializer.sv
// Bench for event_byte_serializer: directed scenarios plus a
// random phase, checked against a queue-based reference model.
module tb_event_byte_serializer;

  localparam int CW    = 4;
  localparam int TW    = 6;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [CW-1:0] in_x;
  logic [CW-1:0] in_y;
  logic [TW-1:0] in_t;
  logic          in_p;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          clr_drop;
  logic [7:0]    drop_count;
  logic [2:0]    fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  // Reference model: stored events, bytes of the event on the
  // port (head = byte currently presented), drop counter.
  logic [15:0] mq [$];
  logic [7:0]  cur [$];
  int          dc = 0;

  event_byte_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_t       (in_t),
    .in_p       (in_p),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .clr_drop   (clr_drop),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input logic [CW-1:0] x,
      input logic [CW-1:0] y, input logic [TW-1:0] t, input logic p);
    int unsigned w;
    w = (int'(p) << (2*CW+TW)) + (int'(x) << (CW+TW))
      + (int'(y) << TW) + int'(t);
    return w[15:0];
  endfunction

  task automatic set_ev(input logic [CW-1:0] x, input logic [CW-1:0] y,
                        input logic [TW-1:0] t, input logic p);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_t = t;
    in_p = p;
  endtask

  task automatic rand_ev();
    set_ev(CW'($urandom), CW'($urandom), TW'($urandom), 1'($urandom));
  endtask

  // Check current outputs against the model, advance the model
  // by one clock, then move to the next falling edge.
  task automatic step();
    logic        full;
    logic [15:0] w;
    chk("valid", {31'd0, out_valid}, {31'd0, cur.size() > 0});
    if (cur.size() > 0) begin
      chk("data", {24'd0, out_data}, {24'd0, cur[0]});
      chk("last", {31'd0, out_last}, {31'd0, cur.size() == 1});
    end
    chk("level", {29'd0, fifo_level}, mq.size());
    chk("drops", {24'd0, drop_count}, dc);
    if (out_valid && out_ready) n_acc++;
    if (!rst_n) begin
      mq.delete();
      cur.delete();
      dc = 0;
    end else begin
      full = (mq.size() == DEPTH);
      if (clr_drop) dc = (in_valid && full) ? 1 : 0;
      else if (in_valid && full && dc < 255) dc++;
      if (cur.size() > 0 && out_ready) void'(cur.pop_front());
      if (cur.size() == 0 && mq.size() > 0) begin
        w = mq.pop_front();
        cur.push_back(w[15:8]);
        cur.push_back(w[7:0]);
      end
      if (in_valid && !full) mq.push_back(pack(in_x, in_y, in_t, in_p));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr_drop = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_t = '0;
    in_p = 1'b0;
    out_ready = 1'b0;
    clr_drop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    chk("rst_last", {31'd0, out_last}, 0);
    chk("rst_level", {29'd0, fifo_level}, 0);
    chk("rst_drops", {24'd0, drop_count}, 0);

    // Single event, sink always ready
    out_ready = 1'b1;
    set_ev(4'hA, 4'h5, 6'h2C, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t1_lat1", {31'd0, out_valid}, 0);
    step();
    chk("t1_lat2", {31'd0, out_valid}, 1);
    chk("t1_b0", {24'd0, out_data}, 32'h69);
    step();
    chk("t1_b1", {24'd0, out_data}, 32'h6C);
    chk("t1_last", {31'd0, out_last}, 1);
    step();
    step();

    // Backpressure on byte 0
    out_ready = 1'b0;
    set_ev(4'hA, 4'h5, 6'h2C, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    repeat (3) begin
      chk("t2_hold", {24'd0, out_data}, 32'h69);
      step();
    end
    out_ready = 1'b1;
    chk("t2_b0", {24'd0, out_data}, 32'h69);
    step();
    chk("t2_b1", {24'd0, out_data}, 32'h6C);
    step();
    step();

    // Overflow: one event parked on the port, then six more
    do_reset();
    out_ready = 1'b0;
    rand_ev();
    step();
    in_valid = 1'b0;
    step();
    repeat (6) begin
      rand_ev();
      step();
    end
    in_valid = 1'b0;
    chk("t3_level", {29'd0, fifo_level}, 4);
    chk("t3_drops", {24'd0, drop_count}, 2);
    n_acc = 0;
    out_ready = 1'b1;
    repeat (14) step();
    chk("t3_bytes", n_acc, 10);

    // Saturation and clear
    do_reset();
    out_ready = 1'b0;
    repeat (310) begin
      rand_ev();
      step();
    end
    chk("t4_sat", {24'd0, drop_count}, 255);
    in_valid = 1'b0;
    clr_drop = 1'b1;
    step();
    chk("t4_clr", {24'd0, drop_count}, 0);
    rand_ev();
    step();
    chk("t4_clr_drop", {24'd0, drop_count}, 1);
    in_valid = 1'b0;
    clr_drop = 1'b0;

    // Back-to-back events with no bubble
    do_reset();
    out_ready = 1'b0;
    repeat (3) begin
      rand_ev();
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (6) begin
      chk("t5_contig", {31'd0, out_valid}, 1);
      step();
    end
    chk("t5_end", {31'd0, out_valid}, 0);

    // Reset in the middle of an event
    do_reset();
    out_ready = 1'b1;
    rand_ev();
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t6_mid", {31'd0, out_valid}, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_valid", {31'd0, out_valid}, 0);
    chk("t6_level", {29'd0, fifo_level}, 0);
    n_acc = 0;
    repeat (5) step();
    chk("t6_nobyte", n_acc, 0);

    // Random traffic
    repeat (400) begin
      if ($urandom_range(0, 1) == 1) rand_ev();
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      clr_drop = ($urandom_range(0, 31) == 0);
      step();
    end
    in_valid = 1'b0;
    clr_drop = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
